// File: rtl/gf1024_pkg.sv
// Shared GF(2^10) definitions for the RS(544,522) constant-vector MAC.
// gf_mul works on any field width up to 31 bits, chosen by its w argument.
package gf1024_pkg;

  localparam int          W_DEF    = 10;
  localparam int          R_DEF    = 22;
  localparam logic [10:0] POLY_DEF = 11'h409;  // x^10 + x^3 + 1

  typedef logic [W_DEF-1:0] sym_t;

  // Shift-and-add multiply. Each doubling of a is reduced right away by
  // XORing in poly, which holds the x^w term, so bit w is cleared again.
  function automatic logic [31:0] gf_mul(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [31:0] poly,
                                         input int          w);
    logic [31:0] res;
    logic [31:0] aa;
    logic [31:0] top;
    res = '0;
    aa  = a;
    top = 32'd1 << w;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        if (b[i]) res = res ^ aa;
        aa = aa << 1;
        if ((aa & top) != '0) aa = aa ^ poly;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gf_vec_mac_lane.sv
// One constant lane: GF multiplier, optional product register, lane
// accumulator and the result register for this lane.
module gf_vec_mac_lane
  import gf1024_pkg::*;
#(
  parameter int           W    = W_DEF,
  parameter logic [W:0]   POLY = POLY_DEF,
  parameter int           PIPE = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] k,
  input  logic [W-1:0] s,
  input  logic         ld_p,     // input fires: capture product
  input  logic         acc_en,   // a product enters the accumulator
  input  logic         acc_sof,
  input  logic         acc_eof,
  output logic [W-1:0] v
);

  logic [31:0]  prod32;
  logic [W-1:0] prod, p_in, acc_q, acc_nxt;

  assign prod32  = gf_mul(32'(k), 32'(s), 32'(POLY), W);
  assign prod    = prod32[W-1:0];
  assign acc_nxt = (acc_sof ? '0 : acc_q) ^ p_in;

  generate
    if (PIPE != 0) begin : g_pipe
      logic [W-1:0] p_q;
      // Product register, loaded on every accepted symbol.
      always_ff @(posedge clk_i) begin
        if (!rst_ni)   p_q <= '0;
        else if (ld_p) p_q <= prod;
      end
      assign p_in = p_q;
    end else begin : g_comb
      assign p_in = prod;
    end
  endgenerate

  // Accumulate; an eof moves the sum to the result and clears the
  // accumulator so the next frame starts clean even without sof.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
      v     <= '0;
    end else if (acc_en) begin
      if (acc_eof) begin
        v     <= acc_nxt;
        acc_q <= '0;
      end else begin
        acc_q <= acc_nxt;
      end
    end
  end

endmodule

// File: rtl/gf_vec_mac_unit.sv
// Streaming GF(2^W) constant-vector MAC: v = XOR over a frame of K_t*s_t
// for R lanes, with valid/ready on both sides.
// Optional frame-length check: define GF_VEC_MAC_LEN_CHECK_EN.
module gf_vec_mac_unit
  import gf1024_pkg::*;
#(
  parameter int         W     = W_DEF,
  parameter int         R     = R_DEF,
  parameter logic [W:0] POLY  = POLY_DEF,
  parameter int         PIPE  = 1
`ifdef GF_VEC_MAC_LEN_CHECK_EN
  ,
  parameter int         N_SYM = 522
`endif
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] s_i,
  input  logic [W-1:0] K_i [0:R-1],
  input  logic         sof_i,
  input  logic         eof_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] v_o [0:R-1],
  output logic         frame_err_o
);

  logic fire, hold;
  logic acc_en, acc_sof, acc_eof;

  assign fire = in_valid_i && in_ready_o;
  assign hold = out_valid_o && !out_ready_i;  // result register cannot take a new eof

  generate
    if (PIPE != 0) begin : g_pipe
      logic p_valid, p_sof, p_eof, advance;
      // Only an eof entry waiting on a held result blocks the stage.
      assign advance    = !(p_valid && p_eof && hold);
      assign in_ready_o = !p_valid || advance;
      assign acc_en     = p_valid && advance;
      assign acc_sof    = p_sof;
      assign acc_eof    = p_eof;

      // Product-stage valid and frame flags travel with the product.
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          p_valid <= 1'b0;
          p_sof   <= 1'b0;
          p_eof   <= 1'b0;
        end else if (advance) begin
          p_valid <= fire;
          p_sof   <= fire && sof_i;
          p_eof   <= fire && eof_i;
        end
      end
    end else begin : g_comb
      assign in_ready_o = !(eof_i && hold);
      assign acc_en     = fire;
      assign acc_sof    = sof_i;
      assign acc_eof    = eof_i;
    end
  endgenerate

  // Result valid: set by an eof landing, cleared when downstream takes it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                out_valid_o <= 1'b0;
    else if (acc_en && acc_eof) out_valid_o <= 1'b1;
    else if (out_ready_i)       out_valid_o <= 1'b0;
  end

  generate
    for (genvar i = 0; i < R; i++) begin : g_lane
      gf_vec_mac_lane #(.W(W), .POLY(POLY), .PIPE(PIPE)) u_lane (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .k       (K_i[i]),
        .s       (s_i),
        .ld_p    (fire),
        .acc_en  (acc_en),
        .acc_sof (acc_sof),
        .acc_eof (acc_eof),
        .v       (v_o[i])
      );
    end
  endgenerate

`ifdef GF_VEC_MAC_LEN_CHECK_EN
  localparam int CW = $clog2(N_SYM + 1);

  logic [CW-1:0] cnt_q, len;
  logic          err_q;

  // Length including the symbol now entering; saturates rather than wraps.
  always_comb begin
    len = cnt_q;
    if (acc_sof)          len = CW'(1);
    else if (cnt_q != '1) len = cnt_q + CW'(1);
  end

  // Symbols counted as they reach the accumulator, so the error pulse
  // lines up with the result load.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (acc_en) begin
        if (acc_eof) begin
          cnt_q <= '0;
          err_q <= (len != CW'(N_SYM)) || (acc_sof && cnt_q != '0);
        end else begin
          cnt_q <= len;
          err_q <= acc_sof && cnt_q != '0;
        end
      end
    end
  end

  assign frame_err_o = err_q;
`else
  assign frame_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gf_vec_mac_unit.sv
// Directed bench for gf_vec_mac_unit (PIPE=1, W=10, R=22).
module tb_gf_vec_mac_unit;

  localparam int W = 10;
  localparam int R = 22;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] s_i;
  logic [W-1:0] K_i [0:R-1];
  logic         sof_i, eof_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] v_o [0:R-1];
  logic         frame_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

`ifdef GF_VEC_MAC_LEN_CHECK_EN
  gf_vec_mac_unit #(.W(W), .R(R), .PIPE(1), .N_SYM(4)) dut (
`else
  gf_vec_mac_unit #(.W(W), .R(R), .PIPE(1)) dut (
`endif
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .s_i         (s_i),
    .K_i         (K_i),
    .sof_i       (sof_i),
    .eof_i       (eof_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .v_o         (v_o),
    .frame_err_o (frame_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_k(input logic [W-1:0] val);
    for (int i = 0; i < R; i++) K_i[i] = val;
  endtask

  // Present one symbol, wait (bounded) for ready, let it fire, drop valid.
  task automatic put(input logic sof, input logic eof, input logic [W-1:0] s);
    int n;
    in_valid_i = 1'b1; sof_i = sof; eof_i = eof; s_i = s;
    #1;
    n = 0;
    while (!in_ready_o && n < 20) begin
      tick(); #1; n++;
    end
    if (n == 20) chk("in_ready_timeout", 32'(in_ready_o), 32'd1);
    tick();
    in_valid_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; in_valid_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
    s_i = '0; out_ready_i = 1'b1; set_k('0);
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_v0", 32'(v_o[0]), 32'd0);
    chk("rst_v21", 32'(v_o[21]), 32'd0);
    chk("rst_frame_err", 32'(frame_err_o), 32'd0);
    rst_ni = 1'b1;

    // Single-symbol frame, K=1, s=0x3FF; result two edges after fire
    set_k(10'h001);
    put(1'b1, 1'b1, 10'h3FF);
    chk("lat_not_yet", 32'(out_valid_o), 32'd0);
    tick();
    chk("single_valid", 32'(out_valid_o), 32'd1);
    chk("single_v0", 32'(v_o[0]), 32'h3FF);
    chk("single_v21", 32'(v_o[21]), 32'h3FF);
`ifndef GF_VEC_MAC_LEN_CHECK_EN
    chk("single_no_err", 32'(frame_err_o), 32'd0);
`endif

    // Reduction: x * x^9 = x^10 = x^3 + 1
    set_k('0); K_i[0] = 10'h002;
    put(1'b1, 1'b1, 10'h200);
    tick();
    chk("reduce_v0", 32'(v_o[0]), 32'h009);
    chk("reduce_v1", 32'(v_o[1]), 32'h000);

    // Two equal terms cancel; three leave one
    set_k(10'h123);
    put(1'b1, 1'b0, 10'h001);
    put(1'b0, 1'b1, 10'h001);
    tick();
    chk("two_valid", 32'(out_valid_o), 32'd1);
    chk("two_v7", 32'(v_o[7]), 32'h000);
    put(1'b1, 1'b0, 10'h001);
    put(1'b0, 1'b0, 10'h001);
    put(1'b0, 1'b1, 10'h001);
    tick();
    chk("three_v0", 32'(v_o[0]), 32'h123);
    chk("three_v21", 32'(v_o[21]), 32'h123);
    tick();
    chk("drained", 32'(out_valid_o), 32'd0);

    // Backpressure: result A held, frame B's eof stalls in the product stage
    out_ready_i = 1'b0;
    for (int i = 0; i < R; i++) K_i[i] = 10'(i);
    put(1'b1, 1'b1, 10'h001);
    tick();
    chk("bp_a_v5", 32'(v_o[5]), 32'h005);
    chk("bp_a_v21", 32'(v_o[21]), 32'h015);
    set_k(10'h123);
    put(1'b1, 1'b0, 10'h001);
    put(1'b0, 1'b1, 10'h002);
    set_k(10'h005);
    in_valid_i = 1'b1; sof_i = 1'b1; eof_i = 1'b1; s_i = 10'h003;
    #1;
    chk("bp_ready_low", 32'(in_ready_o), 32'd0);
    chk("bp_held_valid", 32'(out_valid_o), 32'd1);
    tick(); #1;
    chk("bp_ready_low2", 32'(in_ready_o), 32'd0);
    chk("bp_held_v5", 32'(v_o[5]), 32'h005);
    out_ready_i = 1'b1;
    #1;
    chk("bp_ready_back", 32'(in_ready_o), 32'd1);
    tick();
    in_valid_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
    chk("bp_b_valid", 32'(out_valid_o), 32'd1);
    chk("bp_b_v0", 32'(v_o[0]), 32'h365);
    tick();
    chk("bp_c_valid", 32'(out_valid_o), 32'd1);
    chk("bp_c_v3", 32'(v_o[3]), 32'h00F);
    tick();
    chk("bp_drained", 32'(out_valid_o), 32'd0);

    // Reset mid-frame drops the partial sum; next frame has no sof
    set_k(10'h123);
    put(1'b1, 1'b0, 10'h001);
    rst_ni = 1'b0;
    tick();
    chk("midrst_valid", 32'(out_valid_o), 32'd0);
    rst_ni = 1'b1;
    tick();
    chk("postrst_valid", 32'(out_valid_o), 32'd0);
    set_k(10'h005);
    put(1'b0, 1'b1, 10'h003);
    chk("postrst_lat", 32'(out_valid_o), 32'd0);
    tick();
    chk("postrst_valid1", 32'(out_valid_o), 32'd1);
    chk("postrst_v0", 32'(v_o[0]), 32'h00F);
    chk("postrst_v21", 32'(v_o[21]), 32'h00F);
    tick();

`ifdef GF_VEC_MAC_LEN_CHECK_EN
    // N_SYM=4: a 3-symbol frame is flagged, a 4-symbol frame is not
    put(1'b1, 1'b0, 10'h001);
    put(1'b0, 1'b0, 10'h001);
    put(1'b0, 1'b1, 10'h001);
    tick();
    chk("len3_valid", 32'(out_valid_o), 32'd1);
    chk("len3_err", 32'(frame_err_o), 32'd1);
    tick();
    chk("len3_err_pulse", 32'(frame_err_o), 32'd0);
    put(1'b1, 1'b0, 10'h001);
    put(1'b0, 1'b0, 10'h001);
    put(1'b0, 1'b0, 10'h001);
    put(1'b0, 1'b1, 10'h001);
    tick();
    chk("len4_valid", 32'(out_valid_o), 32'd1);
    chk("len4_err", 32'(frame_err_o), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
